avmm_csr_target: RTL and testbench

//  Parametrised AVMM target register bank: successor to the fixed 16x32 test target model.

---
 rtl/avmm_csr_if.sv | 23 ++
 rtl/avmm_csr_target.sv | 193 +++++++++++++++++++
 tb/tb_avmm_csr_target.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_csr_if.sv
// Avalon-MM command/response bundle between a CSR master and the target bank.
interface avmm_csr_if;
  logic [31:0] avmm_addr;
  logic        avmm_read;
  logic        avmm_write;
  logic [31:0] avmm_wdata;
  logic [3:0]  avmm_byteen;
  logic        avmm_waitrq;
  logic        avmm_rdvalid;
  logic        avmm_wrvalid;
  logic [1:0]  avmm_response;
  logic [31:0] avmm_rdata;

  modport master (
    output avmm_addr, avmm_read, avmm_write, avmm_wdata, avmm_byteen,
    input  avmm_waitrq, avmm_rdvalid, avmm_wrvalid, avmm_response, avmm_rdata
  );

  modport slave (
    input  avmm_addr, avmm_read, avmm_write, avmm_wdata, avmm_byteen,
    output avmm_waitrq, avmm_rdvalid, avmm_wrvalid, avmm_response, avmm_rdata
  );
endinterface

// File: rtl/avmm_csr_target.sv
// Parametrised AVMM CSR target: register bank with wait-state and read-latency
// insertion, byte-enable merging, read-only / write-1-clear masks and response codes.
module avmm_csr_target #(
  parameter int                     NUM_REGS    = 16,
  parameter int                     ADDR_W      = 16,
  parameter int                     WAIT_CYCLES = 0,
  parameter int                     RD_LATENCY  = 1,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]    W1C_MASK    = '0,
  parameter logic [31:0]            BAD_DATA    = 32'h0BAD_0ADD
) (
  input  logic        clk,
  input  logic        rst_n,
  avmm_csr_if.slave   bus,
  output logic [15:0] err_count
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [1:0] RSP_SLVERR = 2'b10;
  localparam logic [1:0] RSP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, STALL, BUSY} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wcnt, wcnt_nxt;
  logic [2:0]        lcnt;
  logic              busy_wr;
  logic              cmd, accept, waitrq;

  logic [31:0]       regs [NUM_REGS];

  logic [31:0]       widx;
  logic [IDX_W-1:0]  idx;
  logic              dec_err, be_err;
  logic [1:0]        rsp_now;
  logic [31:0]       rdat_now;

  logic [1:0]        rsp_p0;
  logic [31:0]       rdat_p0;

  logic              rd_done, wr_done;
  logic [1:0]        done_rsp;
  logic [31:0]       done_rdat;

  logic              rdvalid_p1, wrvalid_p1;
  logic [1:0]        response_p1;
  logic [31:0]       rdata_p1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be,
                                              input logic        w1c);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = w1c ? (cur[8*b +: 8] & ~wd[8*b +: 8]) : wd[8*b +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cmd = bus.avmm_read | bus.avmm_write;

  // Address decode and response classification of the presented command
  assign widx     = 32'(bus.avmm_addr[ADDR_W-1:2]);
  assign idx      = widx[IDX_W-1:0];
  assign dec_err  = ((bus.avmm_addr >> ADDR_W) != 32'd0) ||
                    (widx >= 32'(NUM_REGS)) ||
                    (bus.avmm_addr[1:0] != 2'b00);
  assign be_err   = (bus.avmm_byteen == 4'b0000);
  assign rsp_now  = dec_err ? RSP_DECERR : (be_err ? RSP_SLVERR : RSP_OKAY);
  assign rdat_now = dec_err ? BAD_DATA : (be_err ? 32'd0 : regs[idx]);

  // Next-state, acceptance and waitrequest
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd) begin
          if (WAIT_CYCLES == 0) begin
            accept    = 1'b1;
            state_nxt = BUSY;
          end else begin
            state_nxt = STALL;
            wcnt_nxt  = 4'd1;
          end
        end
      end
      STALL: begin
        if (!cmd) begin
          state_nxt = IDLE;
          wcnt_nxt  = 4'd0;
        end else if (wcnt == 4'(WAIT_CYCLES)) begin
          accept    = 1'b1;
          state_nxt = BUSY;
          wcnt_nxt  = 4'd0;
        end else begin
          wcnt_nxt  = wcnt + 4'd1;
        end
      end
      BUSY: begin
        if (busy_wr || (lcnt == 3'(RD_LATENCY))) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    waitrq = (state == BUSY) ? 1'b1 : (cmd & ~accept);
  end

  // FSM state, wait counter and busy-phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      lcnt    <= 3'd0;
      busy_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (accept) begin
        busy_wr <= bus.avmm_write;
        lcnt    <= 3'd1;
      end else if (state == BUSY) begin
        lcnt <= lcnt + 3'd1;
      end
    end
  end

  // Stage p0: read data and response captured at accept, immune to later writes
  always_ff @(posedge clk) begin
    if (accept) begin
      rsp_p0  <= rsp_now;
      rdat_p0 <= rdat_now;
    end
  end

  // A write wins over a simultaneous read; reads complete RD_LATENCY cycles after accept
  assign wr_done   = accept & bus.avmm_write;
  assign rd_done   = ((RD_LATENCY == 1) && accept && !bus.avmm_write) ||
                     ((state == BUSY) && !busy_wr && (lcnt == 3'(RD_LATENCY - 1)));
  assign done_rsp  = accept ? rsp_now  : rsp_p0;
  assign done_rdat = accept ? rdat_now : rdat_p0;

  // Stage p1: completion pulses, response, held read data and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdvalid_p1  <= 1'b0;
      wrvalid_p1  <= 1'b0;
      response_p1 <= 2'b00;
      rdata_p1    <= 32'd0;
      err_count   <= 16'd0;
    end else begin
      rdvalid_p1 <= rd_done;
      wrvalid_p1 <= wr_done;
      if (rd_done || wr_done) begin
        response_p1 <= done_rsp;
        if (done_rsp != RSP_OKAY) begin
          err_count <= sat_inc(err_count);
        end
      end
      if (rd_done) begin
        rdata_p1 <= done_rdat;
      end
    end
  end

  // Register bank: byte-merged update on an accepted, error-free, writable write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 32'(i);
      end
    end else if (wr_done && (rsp_now == RSP_OKAY) && !RO_MASK[idx]) begin
      regs[idx] <= merge_bytes(regs[idx], bus.avmm_wdata, bus.avmm_byteen, W1C_MASK[idx]);
    end
  end

  assign bus.avmm_waitrq   = waitrq;
  assign bus.avmm_rdvalid  = rdvalid_p1;
  assign bus.avmm_wrvalid  = wrvalid_p1;
  assign bus.avmm_response = response_p1;
  assign bus.avmm_rdata    = rdata_p1;

endmodule

// File: tb/tb_avmm_csr_target.sv
// Bench for avmm_csr_target: directed commands, expected responses queued at
// accept and compared by a monitor when rdvalid/wrvalid pulse.
module tb_avmm_csr_target;

  localparam int RL = 4;
  localparam int WC = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] err_count;
  int          cyc;
  int          checks;
  int          errors;
  int          exp_err;
  logic [31:0] last_rd;

  typedef struct {
    bit          wr;
    logic [1:0]  resp;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];

  avmm_csr_if bus();

  avmm_csr_target #(
    .NUM_REGS    (16),
    .ADDR_W      (16),
    .WAIT_CYCLES (WC),
    .RD_LATENCY  (RL),
    .RO_MASK     (16'h0010),
    .W1C_MASK    (16'h0008),
    .BAD_DATA    (32'h0BAD_0ADD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.avmm_rdvalid || bus.avmm_wrvalid)) begin
        if (q.size() == 0) begin
          chk("unexpected_response", {30'd0, bus.avmm_rdvalid, bus.avmm_wrvalid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("resp_kind", {30'd0, bus.avmm_rdvalid, bus.avmm_wrvalid},
              e.wr ? 32'd1 : 32'd2);
          chk("resp_code", 32'(bus.avmm_response), 32'(e.resp));
          chk("resp_latency", 32'(cyc), 32'(e.due));
          if (!e.wr) begin
            chk("rdata", bus.avmm_rdata, e.data);
          end
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("response_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [1:0] er, input logic [31:0] ed,
                       output int waits);
    bit   acc;
    exp_t e;
    bus.avmm_addr   = a;
    bus.avmm_wdata  = d;
    bus.avmm_byteen = be;
    bus.avmm_read   = rd;
    bus.avmm_write  = wr;
    waits = 0;
    acc   = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (!bus.avmm_waitrq) acc = 1'b1;
      else waits++;
    end
    if (!acc) begin
      chk("accept_timeout", 32'(acc), 32'd1);
    end else begin
      e.wr   = wr;
      e.resp = er;
      e.data = ed;
      e.due  = cyc + (wr ? 1 : RL);
      q.push_back(e);
      if (er != 2'b00) exp_err++;
      if (!wr) last_rd = ed;
    end
    @(posedge clk);
    #1;
    bus.avmm_read  = 1'b0;
    bus.avmm_write = 1'b0;
    drain();
  endtask

  task automatic do_rd(input logic [31:0] a, input logic [3:0] be,
                       input logic [1:0] er, input logic [31:0] ed);
    int w;
    issue(1'b1, 1'b0, a, 32'd0, be, er, ed, w);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [1:0] er);
    int w;
    issue(1'b0, 1'b1, a, d, be, er, 32'd0, w);
  endtask

  initial begin
    int  w;
    bit  acc;
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    exp_err = 0;
    last_rd = 32'd0;
    rst_n   = 1'b0;
    bus.avmm_addr   = 32'd0;
    bus.avmm_wdata  = 32'd0;
    bus.avmm_byteen = 4'd0;
    bus.avmm_read   = 1'b0;
    bus.avmm_write  = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdvalid",  32'(bus.avmm_rdvalid),  32'd0);
    chk("reset_wrvalid",  32'(bus.avmm_wrvalid),  32'd0);
    chk("reset_response", 32'(bus.avmm_response), 32'd0);
    chk("reset_rdata",    bus.avmm_rdata,         32'd0);
    chk("reset_errcnt",   32'(err_count),         32'd0);
    chk("reset_waitrq",   32'(bus.avmm_waitrq),   32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic read of reset value
    do_rd(32'h14, 4'hF, 2'b00, 32'd5);

    // Partial byte-enable write after three wait states
    issue(1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 2'b00, 32'd0, w);
    chk("write_wait_states", 32'(w), 32'(WC));
    do_rd(32'h08, 4'hF, 2'b00, 32'h00BB00DD);

    // rdata holds across a write completion
    do_wr(32'h18, 32'h11223344, 4'hF, 2'b00);
    chk("rdata_hold", bus.avmm_rdata, 32'h00BB00DD);

    // Decode errors: high bits, out-of-range word, misaligned
    do_rd(32'h0001_0000, 4'hF, 2'b11, 32'h0BAD_0ADD);
    do_rd(32'h40, 4'hF, 2'b11, 32'h0BAD_0ADD);
    chk("errcnt_decode", 32'(err_count), 32'd2);
    do_rd(32'h0A, 4'hF, 2'b11, 32'h0BAD_0ADD);
    do_wr(32'h44, 32'hFFFF_FFFF, 4'hF, 2'b11);

    // W1C register 3 (reset value 3): clearing bit 0 leaves 2
    do_wr(32'h0C, 32'h0000_0001, 4'hF, 2'b00);
    do_rd(32'h0C, 4'hF, 2'b00, 32'h0000_0002);

    // Read-only register 4 ignores writes but answers OKAY
    do_wr(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    do_rd(32'h10, 4'hF, 2'b00, 32'd4);

    // Zero byte enables give SLVERR and change nothing
    do_rd(32'h14, 4'h0, 2'b10, 32'd0);
    do_wr(32'h14, 32'hFFFF_FFFF, 4'h0, 2'b10);
    do_rd(32'h14, 4'hF, 2'b00, 32'd5);
    chk("errcnt_after_errors", 32'(err_count), 32'(exp_err));

    // Read and write presented together: the write wins
    issue(1'b1, 1'b1, 32'h1C, 32'h0000_0066, 4'hF, 2'b00, 32'd0, w);
    do_rd(32'h1C, 4'hF, 2'b00, 32'h0000_0066);

    // Command withdrawn during stall: no response, counter restarts
    bus.avmm_addr   = 32'h14;
    bus.avmm_byteen = 4'hF;
    bus.avmm_read   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.avmm_read = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("idle_waitrq", 32'(bus.avmm_waitrq), 32'd0);
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 32'h14, 32'd0, 4'hF, 2'b00, 32'd5, w);
    chk("read_wait_states", 32'(w), 32'(WC));

    // Reset during a 4-cycle read: response dropped, registers restored
    do_wr(32'h00, 32'h1234_5678, 4'hF, 2'b00);
    do_rd(32'h00, 4'hF, 2'b00, 32'h1234_5678);
    bus.avmm_addr   = 32'h00;
    bus.avmm_byteen = 4'hF;
    bus.avmm_read   = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (!bus.avmm_waitrq) acc = 1'b1;
    end
    chk("rst_test_accept", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    bus.avmm_read = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rdvalid", 32'(bus.avmm_rdvalid), 32'd0);
    chk("midrst_waitrq",  32'(bus.avmm_waitrq),  32'd0);
    chk("midrst_errcnt",  32'(err_count),        32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_err = 0;
    repeat (6) @(posedge clk);
    #1;
    do_rd(32'h00, 4'hF, 2'b00, 32'd0);
    do_rd(32'h08, 4'hF, 2'b00, 32'd2);
    chk("final_errcnt", 32'(err_count), 32'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
